// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one block-RAM port between instruction fetch (read-only)
// and data load/store. Grants combinationally, registers the RAM command,
// tags reads so returned words go back to their owner, and bounds fetch
// starvation with a wait counter (fixed priority) or alternates (round-robin).
module bram_arbiter #(
    parameter int unsigned PRIO_DATA = 1,
    parameter int unsigned MAX_WAIT  = 4,
    localparam int unsigned AW = 13,
    localparam int unsigned DW = 32,
    localparam int unsigned MW = 4,
    localparam int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    // fetch port
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [MW-1:0] d_wmask,
    output logic          d_ack,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    // RAM port
    output logic          m_ren,
    output logic [AW-1:0] m_addr,
    output logic          m_wen,
    output logic [DW-1:0] m_wdata,
    output logic [MW-1:0] m_wr_mask,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_rd_valid
);

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    logic          w_grant_i;
    logic          w_grant_d;
    logic          w_rd_issue;

    logic [CW-1:0] r_wait_cnt;
    logic          r_last_owner;

    logic          r_ren;
    logic          r_wen;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [MW-1:0] r_wr_mask;

    logic [1:0]    r_tag_v;
    logic [1:0]    r_tag_own;

    // Pick at most one winner this cycle; nothing is granted while in reset
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (!rst) begin
            if (i_req && d_req) begin
                if (PRIO_DATA != 0) begin
                    if (r_wait_cnt == CW'(MAX_WAIT)) begin
                        w_grant_i = 1'b1;
                    end else begin
                        w_grant_d = 1'b1;
                    end
                end else begin
                    if (r_last_owner == OWN_FETCH) begin
                        w_grant_d = 1'b1;
                    end else begin
                        w_grant_i = 1'b1;
                    end
                end
            end else begin
                w_grant_i = i_req;
                w_grant_d = d_req;
            end
        end
    end

    assign w_rd_issue = w_grant_i | (w_grant_d & ~d_we);

    // Count consecutive cycles a pending fetch has lost, saturating at MAX_WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (!i_req || w_grant_i) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != CW'(MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
        end
    end

    // Remember the last granted port for round-robin tie breaking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= OWN_FETCH;
        end else if (w_grant_i) begin
            r_last_owner <= OWN_FETCH;
        end else if (w_grant_d) begin
            r_last_owner <= OWN_DATA;
        end
    end

    // Register the winner's command; address/data/mask hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ren     <= 1'b0;
            r_wen     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wr_mask <= '0;
        end else begin
            r_ren <= 1'b0;
            r_wen <= 1'b0;
            if (w_grant_i) begin
                r_ren     <= 1'b1;
                r_addr    <= i_addr;
                r_wr_mask <= '0;
            end else if (w_grant_d) begin
                r_addr <= d_addr;
                if (d_we) begin
                    r_wen     <= 1'b1;
                    r_wdata   <= d_wdata;
                    r_wr_mask <= d_wmask;
                end else begin
                    r_ren <= 1'b1;
                end
            end
        end
    end

    // Two-stage read tag aligned with the RAM's registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v   <= '0;
            r_tag_own <= '0;
        end else begin
            r_tag_v   <= {r_tag_v[0], w_rd_issue};
            r_tag_own <= {r_tag_own[0], (w_grant_d ? OWN_DATA : OWN_FETCH)};
        end
    end

    assign i_ack     = w_grant_i;
    assign d_ack     = w_grant_d;

    assign m_ren     = r_ren;
    assign m_wen     = r_wen;
    assign m_addr    = r_addr;
    assign m_wdata   = r_wdata;
    assign m_wr_mask = r_wr_mask;

    assign i_rvalid  = ~rst & m_rd_valid & r_tag_v[1] & (r_tag_own[1] == OWN_FETCH);
    assign d_rvalid  = ~rst & m_rd_valid & r_tag_v[1] & (r_tag_own[1] == OWN_DATA);
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: a fixed-priority instance and a round-robin instance
// share the same requester stimulus, each behind its own 2048x32 RAM model.
module tb_bram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        i_req   = 1'b0;
    logic [12:0] i_addr  = '0;
    logic        d_req   = 1'b0;
    logic        d_we    = 1'b0;
    logic [12:0] d_addr  = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wmask = '0;

    // fixed-priority instance signals
    logic        i_ack_p, i_rvalid_p, d_ack_p, d_rvalid_p, m_ren_p, m_wen_p;
    logic [31:0] i_rdata_p, d_rdata_p, m_wdata_p;
    logic [12:0] m_addr_p;
    logic [3:0]  m_wr_mask_p;
    logic [31:0] ram_rdata_p = '0;
    logic        ram_vld_p   = 1'b0;
    logic [31:0] mem_p [0:2047];

    // round-robin instance signals
    logic        i_ack_r, i_rvalid_r, d_ack_r, d_rvalid_r, m_ren_r, m_wen_r;
    logic [31:0] i_rdata_r, d_rdata_r, m_wdata_r;
    logic [12:0] m_addr_r;
    logic [3:0]  m_wr_mask_r;
    logic [31:0] ram_rdata_r = '0;
    logic        ram_vld_r   = 1'b0;
    logic [31:0] mem_r [0:2047];

    logic        ram_init = 1'b0;

    int checks = 0;
    int errors = 0;

    bram_arbiter #(.PRIO_DATA(1), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack_p), .i_rvalid(i_rvalid_p), .i_rdata(i_rdata_p),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_ack(d_ack_p), .d_rvalid(d_rvalid_p), .d_rdata(d_rdata_p),
        .m_ren(m_ren_p), .m_addr(m_addr_p), .m_wen(m_wen_p), .m_wdata(m_wdata_p),
        .m_wr_mask(m_wr_mask_p), .m_rdata(ram_rdata_p), .m_rd_valid(ram_vld_p)
    );

    bram_arbiter #(.PRIO_DATA(0), .MAX_WAIT(4)) dut_rr (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack_r), .i_rvalid(i_rvalid_r), .i_rdata(i_rdata_r),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_ack(d_ack_r), .d_rvalid(d_rvalid_r), .d_rdata(d_rdata_r),
        .m_ren(m_ren_r), .m_addr(m_addr_r), .m_wen(m_wen_r), .m_wdata(m_wdata_r),
        .m_wr_mask(m_wr_mask_r), .m_rdata(ram_rdata_r), .m_rd_valid(ram_vld_r)
    );

    // RAM models: 1-cycle registered read, byte-masked write (mask bit3 -> [7:0])
    always @(posedge clk) begin
        if (!ram_init) begin
            mem_p[4]  <= 32'hDEADBEEF;  mem_r[4]  <= 32'hDEADBEEF;
            mem_p[8]  <= 32'hAABBCCDD;  mem_r[8]  <= 32'hAABBCCDD;
            mem_p[12] <= 32'h0C0C0C0C;  mem_r[12] <= 32'h0C0C0C0C;
            mem_p[16] <= 32'h16161616;  mem_r[16] <= 32'h16161616;
            mem_p[20] <= 32'h20202020;  mem_r[20] <= 32'h20202020;
            ram_init  <= 1'b1;
        end else begin
            if (m_wen_p)
                for (int b = 0; b < 4; b++)
                    if (m_wr_mask_p[3-b]) mem_p[m_addr_p[12:2]][8*b +: 8] <= m_wdata_p[8*b +: 8];
            if (m_wen_r)
                for (int b = 0; b < 4; b++)
                    if (m_wr_mask_r[3-b]) mem_r[m_addr_r[12:2]][8*b +: 8] <= m_wdata_r[8*b +: 8];
        end
        ram_vld_p <= m_ren_p;
        ram_vld_r <= m_ren_r;
        if (m_ren_p) ram_rdata_p <= mem_p[m_addr_p[12:2]];
        if (m_ren_r) ram_rdata_r <= mem_r[m_addr_r[12:2]];
    end

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 13'h010; d_addr = 13'h030;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checks++; if (i_ack_p !== 1'b0 || d_ack_p !== 1'b0) begin errors++; $display("FAIL reset_acks cyc %0d got i=%b d=%b want 0 0", k, i_ack_p, d_ack_p); end
            checks++; if (i_ack_r !== 1'b0 || d_ack_r !== 1'b0) begin errors++; $display("FAIL reset_acks_rr cyc %0d got i=%b d=%b want 0 0", k, i_ack_r, d_ack_r); end
            checks++; if (m_ren_p !== 1'b0 || m_wen_p !== 1'b0) begin errors++; $display("FAIL reset_cmd cyc %0d got ren=%b wen=%b want 0 0", k, m_ren_p, m_wen_p); end
            checks++; if (m_addr_p !== 13'h0 || m_wdata_p !== 32'h0 || m_wr_mask_p !== 4'h0) begin errors++; $display("FAIL reset_fields got addr=%h wdata=%h mask=%h want 0", m_addr_p, m_wdata_p, m_wr_mask_p); end
            checks++; if (i_rvalid_p !== 1'b0 || d_rvalid_p !== 1'b0) begin errors++; $display("FAIL reset_rvalid got i=%b d=%b want 0 0", i_rvalid_p, d_rvalid_p); end
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (d_ack_p !== 1'b1 || i_ack_p !== 1'b0) begin errors++; $display("FAIL post_reset_grant got d=%b i=%b want 1 0", d_ack_p, i_ack_p); end
        @(negedge clk); i_req = 1'b0; d_req = 1'b0; #1;
        checks++; if (m_ren_p !== 1'b1 || m_addr_p !== 13'h030) begin errors++; $display("FAIL post_reset_cmd got ren=%b addr=%h want 1 030", m_ren_p, m_addr_p); end
        @(negedge clk); #1;
        checks++; if (d_rvalid_p !== 1'b1 || d_rdata_p !== 32'h0C0C0C0C) begin errors++; $display("FAIL post_reset_read got v=%b data=%h want 1 0c0c0c0c", d_rvalid_p, d_rdata_p); end
        checks++; if (i_rvalid_p !== 1'b0) begin errors++; $display("FAIL post_reset_irvalid got %b want 0", i_rvalid_p); end
        @(negedge clk);
    endtask

    task automatic test_fetch();
        @(negedge clk); i_req = 1'b1; i_addr = 13'h010; #1;
        checks++; if (i_ack_p !== 1'b1 || d_ack_p !== 1'b0) begin errors++; $display("FAIL fetch_ack got i=%b d=%b want 1 0", i_ack_p, d_ack_p); end
        @(negedge clk); i_req = 1'b0; #1;
        checks++; if (m_ren_p !== 1'b1 || m_wen_p !== 1'b0 || m_addr_p !== 13'h010 || m_wr_mask_p !== 4'h0) begin errors++; $display("FAIL fetch_cmd got ren=%b wen=%b addr=%h mask=%h want 1 0 010 0", m_ren_p, m_wen_p, m_addr_p, m_wr_mask_p); end
        checks++; if (i_rvalid_p !== 1'b0) begin errors++; $display("FAIL fetch_early_rvalid got %b want 0", i_rvalid_p); end
        @(negedge clk); #1;
        checks++; if (i_rvalid_p !== 1'b1 || i_rdata_p !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_data got v=%b data=%h want 1 deadbeef", i_rvalid_p, i_rdata_p); end
        checks++; if (d_rvalid_p !== 1'b0) begin errors++; $display("FAIL fetch_d_rvalid got %b want 0", d_rvalid_p); end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 13'h020; d_wdata = 32'h11223344; d_wmask = 4'b1000; #1;
        checks++; if (d_ack_p !== 1'b1 || i_ack_p !== 1'b0) begin errors++; $display("FAIL write_ack got d=%b i=%b want 1 0", d_ack_p, i_ack_p); end
        @(negedge clk); d_we = 1'b0; #1;
        checks++; if (m_wen_p !== 1'b1 || m_ren_p !== 1'b0 || m_addr_p !== 13'h020 || m_wdata_p !== 32'h11223344 || m_wr_mask_p !== 4'b1000) begin
            errors++; $display("FAIL write_cmd got wen=%b ren=%b addr=%h wdata=%h mask=%b want 1 0 020 11223344 1000", m_wen_p, m_ren_p, m_addr_p, m_wdata_p, m_wr_mask_p); end
        checks++; if (d_ack_p !== 1'b1) begin errors++; $display("FAIL read_ack_b2b got %b want 1", d_ack_p); end
        @(negedge clk); d_req = 1'b0; #1;
        checks++; if (m_ren_p !== 1'b1 || m_wen_p !== 1'b0) begin errors++; $display("FAIL read_cmd got ren=%b wen=%b want 1 0", m_ren_p, m_wen_p); end
        checks++; if (d_rvalid_p !== 1'b0) begin errors++; $display("FAIL write_no_rvalid got %b want 0", d_rvalid_p); end
        @(negedge clk); #1;
        checks++; if (d_rvalid_p !== 1'b1 || d_rdata_p !== 32'hAABBCC44) begin errors++; $display("FAIL raw_data got v=%b data=%h want 1 aabbcc44", d_rvalid_p, d_rdata_p); end
        checks++; if (i_rvalid_p !== 1'b0) begin errors++; $display("FAIL raw_i_rvalid got %b want 0", i_rvalid_p); end
        // zero-mask write is accepted but changes nothing
        @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_wdata = 32'hFFFFFFFF; d_wmask = 4'b0000; #1;
        checks++; if (d_ack_p !== 1'b1) begin errors++; $display("FAIL zmask_ack got %b want 1", d_ack_p); end
        @(negedge clk); d_we = 1'b0; #1;
        checks++; if (m_wen_p !== 1'b1 || m_wr_mask_p !== 4'h0 || m_wdata_p !== 32'hFFFFFFFF) begin errors++; $display("FAIL zmask_cmd got wen=%b mask=%h wdata=%h want 1 0 ffffffff", m_wen_p, m_wr_mask_p, m_wdata_p); end
        @(negedge clk); d_req = 1'b0;
        @(negedge clk); #1;
        checks++; if (d_rvalid_p !== 1'b1 || d_rdata_p !== 32'hAABBCC44) begin errors++; $display("FAIL zmask_data got v=%b data=%h want 1 aabbcc44", d_rvalid_p, d_rdata_p); end
        @(negedge clk); #1;
        checks++; if (d_rvalid_p !== 1'b0) begin errors++; $display("FAIL zmask_extra_rvalid got %b want 0", d_rvalid_p); end
    endtask

    task automatic test_starvation();
        logic exp_i;
        @(negedge clk); i_req = 1'b1; i_addr = 13'h010; d_req = 1'b1; d_we = 1'b0; d_addr = 13'h030;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp_i = (k == 4) || (k == 9);
            checks++; if (i_ack_p !== exp_i || d_ack_p !== !exp_i) begin errors++; $display("FAIL starve_grant cyc %0d got i=%b d=%b want %b %b", k, i_ack_p, d_ack_p, exp_i, !exp_i); end
        end
        @(negedge clk); i_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_round_robin();
        int j;
        @(negedge clk); rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin i_req = 1'b1; i_addr = 13'h040; d_req = 1'b1; d_we = 1'b0; d_addr = 13'h050; end
            if (k == 6) begin i_req = 1'b0; d_req = 1'b0; end
            #1;
            if (k < 6) begin
                checks++; if (d_ack_r !== (k % 2 == 0) || i_ack_r !== (k % 2 == 1)) begin errors++; $display("FAIL rr_grant cyc %0d got d=%b i=%b want %b %b", k, d_ack_r, i_ack_r, (k % 2 == 0), (k % 2 == 1)); end
            end
            if (k >= 2) begin
                j = k - 2;
                checks++; if (d_rvalid_r !== (j % 2 == 0) || i_rvalid_r !== (j % 2 == 1)) begin errors++; $display("FAIL rr_route cyc %0d got d=%b i=%b want %b %b", k, d_rvalid_r, i_rvalid_r, (j % 2 == 0), (j % 2 == 1)); end
                if (j % 2 == 0) begin
                    checks++; if (d_rdata_r !== 32'h20202020) begin errors++; $display("FAIL rr_ddata cyc %0d got %h want 20202020", k, d_rdata_r); end
                end else begin
                    checks++; if (i_rdata_r !== 32'h16161616) begin errors++; $display("FAIL rr_idata cyc %0d got %h want 16161616", k, i_rdata_r); end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        @(negedge clk); i_req = 1'b1; i_addr = 13'h010; #1;
        checks++; if (i_ack_p !== 1'b1) begin errors++; $display("FAIL midrst_ack got %b want 1", i_ack_p); end
        @(negedge clk); i_req = 1'b0; rst = 1'b1; #1;
        checks++; if (m_ren_p !== 1'b1) begin errors++; $display("FAIL midrst_cmd got ren=%b want 1", m_ren_p); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (i_rvalid_p !== 1'b0 || m_ren_p !== 1'b0) begin errors++; $display("FAIL midrst_drop got rvalid=%b ren=%b want 0 0", i_rvalid_p, m_ren_p); end
        @(negedge clk); #1;
        checks++; if (i_rvalid_p !== 1'b0) begin errors++; $display("FAIL midrst_late got %b want 0", i_rvalid_p); end
        @(negedge clk); i_req = 1'b1; #1;
        checks++; if (i_ack_p !== 1'b1) begin errors++; $display("FAIL after_rst_ack got %b want 1", i_ack_p); end
        @(negedge clk); i_req = 1'b0; #1;
        checks++; if (i_rvalid_p !== 1'b0 || m_ren_p !== 1'b1) begin errors++; $display("FAIL after_rst_n1 got rvalid=%b ren=%b want 0 1", i_rvalid_p, m_ren_p); end
        @(negedge clk); #1;
        checks++; if (i_rvalid_p !== 1'b1 || i_rdata_p !== 32'hDEADBEEF) begin errors++; $display("FAIL after_rst_data got v=%b data=%h want 1 deadbeef", i_rvalid_p, i_rdata_p); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write_read();
        test_starvation();
        test_round_robin();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
